tl_cntr_multi: RTL and testbench

TL_CNTR_MULTI -- requirements
Module: tl_cntr_multi

---
 rtl/tl_pkg.sv | 24 ++
 rtl/tl_rr_pick.sv | 27 ++
 rtl/tl_cntr_multi.sv | 111 +++++++++++
 tb/tb_tl_cntr_multi.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared light codes, phase encoding and width helper for the multi-road traffic controller.
// Pure definitions: no latency, no flow control.
package tl_pkg;

    localparam logic [1:0] LC_GREEN  = 2'b00;
    localparam logic [1:0] LC_YELLOW = 2'b01;
    localparam logic [1:0] LC_RED    = 2'b10;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    function automatic int tl_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Round-robin pick of the next requesting road after cur, excluding cur itself.
// Purely combinational; falls back to cur+1 with found=0 when nothing else requests.
module tl_rr_pick
    import tl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = tl_clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] cur,
    output logic [IW-1:0] nxt,
    output logic          found
);

    // Scan farthest-first so the nearest requester after cur wins.
    always_comb begin
        nxt   = IW'((int'(cur) + 1) % N);
        found = 1'b0;
        for (int k = N - 1; k >= 1; k--) begin
            if (req[(int'(cur) + k) % N]) begin
                nxt   = IW'((int'(cur) + k) % N);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_cntr_multi.sv
// Demand-driven traffic controller: GREEN -> YELLOW -> ALLRED -> next road, with min/max green dwell.
// Outputs decoded from registered state only (one-cycle response to T); no backpressure.
module tl_cntr_multi
    import tl_pkg::*;
#(
    parameter int N_ROADS    = 4,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_ROADS-1:0]            T,
    output logic [2*N_ROADS-1:0]          L,
    output logic [tl_clog2(N_ROADS)-1:0]  active,
    output logic [1:0]                    phase
);

    localparam int AW   = tl_clog2(N_ROADS);
    localparam int CM1  = (GREEN_MAX > YELLOW_CYC) ? GREEN_MAX : YELLOW_CYC;
    localparam int CMAX = (CM1 > ALLRED_CYC) ? CM1 : ALLRED_CYC;
    localparam int CW   = tl_clog2(CMAX + 1);

    // Counter holds dwell-1, so thresholds are compared one below the dwell value.
    localparam logic [CW-1:0] C_GMIN = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] C_GMAX = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] C_GSAT = CW'(GREEN_MAX);
    localparam logic [CW-1:0] C_YEL  = CW'(YELLOW_CYC - 1);
    localparam logic [CW-1:0] C_AR   = CW'(ALLRED_CYC - 1);

    phase_e         ph;
    logic [CW-1:0]  cnt;
    logic           other_dmd;
    logic           green_go;
    logic [AW-1:0]  pick_nxt;
    logic           pick_found;

    tl_rr_pick #(
        .N  (N_ROADS),
        .IW (AW)
    ) u_pick (
        .req   (T),
        .cur   (active),
        .nxt   (pick_nxt),
        .found (pick_found)
    );

    always_comb begin
        other_dmd = 1'b0;
        for (int j = 0; j < N_ROADS; j++) begin
            if (T[j] && (j != int'(active))) other_dmd = 1'b1;
        end
    end

    assign green_go = (cnt >= C_GMIN) && other_dmd && (!T[active] || (cnt >= C_GMAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph     <= PH_GREEN;
            active <= '0;
            cnt    <= '0;
        end else begin
            case (ph)
                PH_GREEN: begin
                    if (green_go) begin
                        ph  <= PH_YELLOW;
                        cnt <= '0;
                    end else if (cnt < C_GSAT) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PH_YELLOW: begin
                    if (cnt >= C_YEL) begin
                        ph  <= PH_ALLRED;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PH_ALLRED: begin
                    // When no one else waits, the picker already falls back to active+1.
                    if (cnt >= C_AR) begin
                        ph     <= PH_GREEN;
                        cnt    <= '0;
                        active <= pick_nxt;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    ph  <= PH_GREEN;
                    cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        L = {N_ROADS{LC_RED}};
        for (int i = 0; i < N_ROADS; i++) begin
            if (int'(active) == i) begin
                if (ph == PH_GREEN)       L[2*i +: 2] = LC_GREEN;
                else if (ph == PH_YELLOW) L[2*i +: 2] = LC_YELLOW;
            end
        end
    end

    assign phase = ph;

endmodule

// File: tb/tb_tl_cntr_multi.sv
// Directed bench: each cycle pushes the hand-derived phase/active/L into a queue; a negedge monitor pops and compares.
module tb_tl_cntr_multi;

    localparam logic [1:0] PG = 2'b00;
    localparam logic [1:0] PY = 2'b01;
    localparam logic [1:0] PA = 2'b10;

    logic       clk;
    logic       reset;
    logic [3:0] T;
    logic [7:0] L;
    logic [1:0] active;
    logic [1:0] phase;

    typedef struct {
        logic [7:0] l;
        logic [1:0] ph;
        logic [1:0] act;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    tl_cntr_multi #(
        .N_ROADS    (4),
        .GREEN_MIN  (4),
        .GREEN_MAX  (8),
        .YELLOW_CYC (2),
        .ALLRED_CYC (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .T      (T),
        .L      (L),
        .active (active),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_l(input logic [1:0] ph, input int act);
        logic [7:0] v;
        v = 8'b10_10_10_10;
        if (ph == PG)      v[2*act +: 2] = 2'b00;
        else if (ph == PY) v[2*act +: 2] = 2'b01;
        return v;
    endfunction

    // Drive one cycle, then record what the outputs must show during that cycle.
    task automatic cycn(input logic [3:0] t, input logic r, input logic [1:0] ph,
                        input int act, input int n, input string nm);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            T     = t;
            reset = r;
            #1;
            e.l   = exp_l(ph, act);
            e.ph  = ph;
            e.act = 2'(act);
            e.nm  = nm;
            q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                assert (L[2*i +: 2] != 2'b11)
                else begin
                    n_miss++;
                    $display("FAIL code11 road %0d: L=%b required no 11 pair", i, L);
                end
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (L !== e.l || phase !== e.ph || active !== e.act) begin
                    n_miss++;
                    $display("FAIL %s @%0t: L=%b phase=%b active=%0d required L=%b phase=%b active=%0d",
                             e.nm, $time, L, phase, active, e.l, e.ph, e.act);
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        T     = 4'b0000;
        @(posedge clk);
        #1;

        // Idle: no demand anywhere keeps road 0 green indefinitely.
        cycn(4'b0000, 1'b1, PG, 0, 2,  "a_rst");
        cycn(4'b0000, 1'b0, PG, 0, 20, "a_idle");

        // Single request on road 2 from reset.
        cycn(4'b0100, 1'b1, PG, 0, 1, "b_rst");
        cycn(4'b0100, 1'b0, PG, 0, 4, "b_g0");
        cycn(4'b0100, 1'b0, PY, 0, 2, "b_y0");
        cycn(4'b0100, 1'b0, PA, 0, 1, "b_ar0");
        cycn(4'b0100, 1'b0, PG, 2, 3, "b_g2");

        // Active road keeps requesting: green capped at GREEN_MAX.
        cycn(4'b0011, 1'b1, PG, 0, 1, "c_rst");
        cycn(4'b0011, 1'b0, PG, 0, 8, "c_g0_max");
        cycn(4'b0011, 1'b0, PY, 0, 2, "c_y0");
        cycn(4'b0011, 1'b0, PA, 0, 1, "c_ar0");
        cycn(4'b0011, 1'b0, PG, 1, 2, "c_g1");

        // Reach road 3, then wrap to road 1; T wiggles in ALLRED/YELLOW without effect on timing.
        cycn(4'b1000, 1'b1, PG, 0, 1, "d_rst");
        cycn(4'b1000, 1'b0, PG, 0, 4, "d_g0");
        cycn(4'b1000, 1'b0, PY, 0, 2, "d_y0");
        cycn(4'b1000, 1'b0, PA, 0, 1, "d_ar0");
        cycn(4'b0010, 1'b0, PG, 3, 4, "d_g3");
        cycn(4'b1111, 1'b0, PY, 3, 1, "d_y3a");
        cycn(4'b0000, 1'b0, PY, 3, 1, "d_y3b");
        cycn(4'b0010, 1'b0, PA, 3, 1, "d_ar3");
        cycn(4'b0010, 1'b0, PG, 1, 2, "d_g1_wrap");

        // Demand vanishes once yellow starts: fall back to active+1.
        cycn(4'b0100, 1'b1, PG, 0, 1, "e_rst");
        cycn(4'b0100, 1'b0, PG, 0, 4, "e_g0");
        cycn(4'b0000, 1'b0, PY, 0, 2, "e_y0");
        cycn(4'b0000, 1'b0, PA, 0, 1, "e_ar0");
        cycn(4'b0000, 1'b0, PG, 1, 3, "e_g1_fallback");

        // Reset asserted mid-yellow of road 2 takes effect within the same cycle.
        cycn(4'b0100, 1'b1, PG, 0, 1, "f_rst");
        cycn(4'b0100, 1'b0, PG, 0, 4, "f_g0");
        cycn(4'b0100, 1'b0, PY, 0, 2, "f_y0");
        cycn(4'b0100, 1'b0, PA, 0, 1, "f_ar0");
        cycn(4'b0001, 1'b0, PG, 2, 4, "f_g2");
        cycn(4'b0001, 1'b0, PY, 2, 1, "f_y2");
        cycn(4'b0001, 1'b1, PG, 0, 1, "f_rst_mid_y");
        cycn(4'b0000, 1'b0, PG, 0, 3, "f_after_rst");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
